// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pkg: shared types and pixel helpers for the LED pattern source   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package led_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_CHASE    = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_OFF      = 2'd3
  } pattern_mode_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_LATCH  = 2'd2
  } state_t;

  // brightness+1 makes full scale (255) pass values through unchanged
  function automatic logic [7:0] scale8(input logic [7:0] x, input logic [7:0] brightness);
    logic [15:0] w_prod;
    w_prod = {8'd0, x} * ({8'd0, brightness} + 16'd1);
    return w_prod[15:8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pixel_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pixel_calc: combinational GRB colour for one pixel of a pattern  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_pixel_calc
  import led_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic [1:0]       mode,
  input  logic [IDX_W-1:0] index,
  input  logic [IDX_W-1:0] chase_pos,
  input  logic [7:0]       frame_lsb,
  input  logic [7:0]       brightness,
  output grb_t             pixel
);

  logic [7:0] w_full;
  logic [7:0] w_grad_v;

  always_comb begin
    w_full   = scale8(8'hFF, brightness);
    w_grad_v = 8'(index) + frame_lsb;
    pixel    = '0;
    case (pattern_mode_t'(mode))
      MODE_SOLID: begin
        pixel.g = w_full;
        pixel.r = w_full;
        pixel.b = w_full;
      end
      MODE_CHASE: begin
        if (index == chase_pos) pixel.r = w_full;
      end
      MODE_GRADIENT: begin
        pixel.g = scale8(w_grad_v, brightness);
        pixel.r = scale8(~w_grad_v, brightness);
      end
      default: pixel = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pattern_gen: streams one GRB frame per start, then a latch gap   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 60,
  parameter int RESET_CYCLES = 30000,
  parameter int FCNT_W       = 16
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic              start,
  input  logic              repeat_en,
  input  logic [1:0]        mode,
  input  logic [7:0]        brightness,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int GAP_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_index, r_chase_pos, w_chase_nxt, w_calc_index;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [FCNT_W-1:0] r_frame_cnt, w_frame_nxt;
  logic [1:0]        r_mode, w_calc_mode;
  logic [7:0]        r_bright, w_calc_bright;
  grb_t              r_pix, w_pix;
  logic              w_is_last, w_xfer, w_gap_done, w_load_frame, w_advance;

  assign w_is_last    = (r_index == LAST_IDX);
  assign w_xfer       = (r_state == ST_STREAM) && pix_ready;
  assign w_gap_done   = (r_state == ST_LATCH) && (r_gap_cnt == GAP_LAST);
  assign w_load_frame = ((r_state == ST_IDLE) && start) || (w_gap_done && repeat_en);
  assign w_advance    = w_xfer && !w_is_last;

  // Next-frame counters feed the calc so a repeated frame's pixel 0 already sees them
  assign w_frame_nxt = w_gap_done ? r_frame_cnt + FCNT_W'(1) : r_frame_cnt;
  assign w_chase_nxt = !w_gap_done            ? r_chase_pos :
                       (r_chase_pos == LAST_IDX) ? '0 : r_chase_pos + IDX_W'(1);

  assign w_calc_mode   = w_load_frame ? mode : r_mode;
  assign w_calc_bright = w_load_frame ? brightness : r_bright;
  assign w_calc_index  = w_load_frame ? '0 : r_index + IDX_W'(1);

  led_pixel_calc #(
    .IDX_W(IDX_W)
  ) u_pixel_calc (
    .mode      (w_calc_mode),
    .index     (w_calc_index),
    .chase_pos (w_chase_nxt),
    .frame_lsb (8'(w_frame_nxt)),
    .brightness(w_calc_bright),
    .pixel     (w_pix)
  );

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_xfer && w_is_last) w_state_nxt = ST_LATCH;
      ST_LATCH:  if (w_gap_done) w_state_nxt = repeat_en ? ST_STREAM : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_valid = (r_state == ST_STREAM);
    pix_last  = pix_valid && w_is_last;
    busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= '0;
      r_bright    <= '0;
      r_index     <= '0;
      r_pix       <= '0;
      r_gap_cnt   <= '0;
      r_frame_cnt <= '0;
      r_chase_pos <= '0;
    end else begin
      if (w_load_frame) begin
        r_mode   <= mode;
        r_bright <= brightness;
      end
      if (w_load_frame)   r_index <= '0;
      else if (w_advance) r_index <= r_index + IDX_W'(1);
      if (w_load_frame || w_advance) r_pix <= w_pix;
      if ((r_state == ST_LATCH) && !w_gap_done) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      else                                      r_gap_cnt <= '0;
      r_frame_cnt <= w_frame_nxt;
      r_chase_pos <= w_chase_nxt;
    end
  end

  assign pix_data  = r_pix;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Pixel source directly upstream of led_driver in the anglerfish LED design.
- On a start pulse, streams one frame of NUM_LEDS 24-bit GRB pixels over a valid/ready handshake.
- After the frame, holds a latch gap so the strip commits the frame, then advances an animation frame counter.
- top_level drives start from a button edge; pixels go to led_driver, whose serial output leaves on pmoda.

Parameters:
- NUM_LEDS, 60, pixels per frame; legal range 1..1023.
- RESET_CYCLES, 30000, clk_100mhz cycles of latch gap after the last pixel (300 us at 100 MHz).
- FCNT_W, 16, width of frame_cnt.

Ports:
- clk_100mhz  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to send one frame.
- repeat_en  input  1  when high, frames run back to back without further start pulses.
- mode  input  2  pattern select: 0 SOLID, 1 CHASE, 2 GRADIENT, 3 OFF.
- brightness  input  8  global scale factor.
- pix_data  output  24  pixel colour {G[7:0],R[7:0],B[7:0]}.
- pix_valid  output  1  pix_data is valid.
- pix_ready  input  1  led_driver accepts the pixel.
- pix_last  output  1  qualifies the final pixel of the frame.
- busy  output  1  high in STREAM and LATCH.
- frame_cnt  output  FCNT_W  number of completed frames; wraps.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs reset to 0: pix_valid, pix_last, busy, pix_data, frame_cnt. Internal pixel index and chase position also reset to 0. pix_valid falls immediately on reset assertion, including mid-frame.
- Transfer: a pixel transfers on any clock edge where pix_valid and pix_ready are both high.
- Handshake hold: while pix_valid is high and pix_ready is low, pix_data and pix_last hold stable.
- IDLE:
  - start=1 at edge N latches mode and brightness into frame registers and resets the index to 0.
  - From edge N the block is in STREAM, with pix_valid=1, busy=1 and pixel 0 on pix_data (one-cycle latency).
- STREAM:
  - On a transfer with index < NUM_LEDS-1, the next edge presents pixel index+1, with no bubble.
  - pix_last=1 exactly while index == NUM_LEDS-1. With NUM_LEDS=1, pixel 0 carries pix_last.
  - On the transfer of the last pixel, the next edge enters LATCH with pix_valid=0, pix_last=0 and the gap counter cleared.
- LATCH:
  - Counts RESET_CYCLES cycles.
  - On its final cycle: frame_cnt += 1 (modulo 2^FCNT_W), and chase_pos advances, wrapping NUM_LEDS-1 → 0.
  - Then, if repeat_en=1, go to STREAM with index 0 and freshly latched mode/brightness. Otherwise go to IDLE with busy=0.
- start is ignored outside IDLE; it is not queued.
- mode and brightness changes mid-frame are ignored until the next frame latch.
- Pixel function (v8 is 8-bit):
  - scale(x) = (x * (brightness+1)) >> 8, computed in 16 bits and truncated to 8 bits.
  - SOLID: G=R=B=scale(255).
  - CHASE: R=scale(255) at index == chase_pos; all other pixels 0.
  - GRADIENT: v = (index + frame_cnt[7:0]) mod 256; G=scale(v), R=scale(255-v), B=0.
  - OFF: 0.
- Simultaneous events:
  - Reset dominates everything.
  - start arriving on the same edge LATCH returns to IDLE is ignored.

Decomposition:
- Shared package led_pkg:
  - pattern_mode_t enum (SOLID, CHASE, GRADIENT, OFF).
  - grb_t packed struct {g,r,b}.
  - PIX_W=24.
  - state enum (IDLE, STREAM, LATCH).
  - Function scale8.
- Sub-module led_pixel_calc: combinational (mode, index, chase_pos, frame_cnt, brightness) → grb_t. Registered by led_pattern_gen on load.

Test Plan:
- SOLID, brightness=255, NUM_LEDS=4, pix_ready always 1, start pulse → pix_valid high 4 consecutive cycles starting 1 cycle after start, each pixel 0xFFFFFF, pix_last on the 4th; brightness=127 → 0x7F7F7F.
- GRADIENT, frame_cnt=0, brightness=255 → pixel0=0x00FF00, pixel1=0x01FE00. Second frame (frame_cnt=1): pixel0=0x01FE00.
- Backpressure: pix_ready toggling 1,0,0,1 in CHASE → pix_data and pix_last stable while stalled, no pixel lost or duplicated; exactly NUM_LEDS transfers.
- Latch/repeat: RESET_CYCLES=10, repeat_en=0 → busy high through 10 gap cycles, frame_cnt 0→1, then IDLE. With repeat_en=1, the next frame's pixel0 appears with no start pulse, and CHASE's lit pixel moves 0→1.
- Ignored inputs: start mid-STREAM and a mode change mid-frame → frame length and content unchanged.
- Reset mid-frame: rst_n low at pixel 2 → pix_valid, busy and frame_cnt are 0 before the next edge. After release, a start pulse yields pixel 0 again.
